// File: rtl/ahb_master_mux_if.sv
// Bus bundle for ahb_master_mux: per-master request side in, shared AHB side out.
interface ahb_master_mux_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          grant_0, grant_1, grant_2, grant_3;
  logic          hready;
  logic [AW-1:0] haddr_0, haddr_1, haddr_2, haddr_3;
  logic [1:0]    htrans_0, htrans_1, htrans_2, htrans_3;
  logic          hwrite_0, hwrite_1, hwrite_2, hwrite_3;
  logic [2:0]    hsize_0, hsize_1, hsize_2, hsize_3;
  logic [DW-1:0] hwdata_0, hwdata_1, hwdata_2, hwdata_3;

  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [1:0]    hmaster;
  logic [1:0]    hmaster_data;
  logic          data_active;
  logic          grant_err;
  logic [7:0]    err_cnt;
  logic [15:0]   handover_cnt;

  // The mux itself: consumes grants and master buses, drives the shared bus.
  modport slave (
    input  grant_0, grant_1, grant_2, grant_3, hready,
    input  haddr_0, haddr_1, haddr_2, haddr_3,
    input  htrans_0, htrans_1, htrans_2, htrans_3,
    input  hwrite_0, hwrite_1, hwrite_2, hwrite_3,
    input  hsize_0, hsize_1, hsize_2, hsize_3,
    input  hwdata_0, hwdata_1, hwdata_2, hwdata_3,
    output haddr, htrans, hwrite, hsize, hwdata,
    output hmaster, hmaster_data, data_active, grant_err, err_cnt, handover_cnt
  );

  // The masters/arbiter side: drives requests, observes the shared bus.
  modport master (
    output grant_0, grant_1, grant_2, grant_3, hready,
    output haddr_0, haddr_1, haddr_2, haddr_3,
    output htrans_0, htrans_1, htrans_2, htrans_3,
    output hwrite_0, hwrite_1, hwrite_2, hwrite_3,
    output hsize_0, hsize_1, hsize_2, hsize_3,
    output hwdata_0, hwdata_1, hwdata_2, hwdata_3,
    input  haddr, htrans, hwrite, hsize, hwdata,
    input  hmaster, hmaster_data, data_active, grant_err, err_cnt, handover_cnt
  );
endinterface

// File: rtl/ahb_master_mux.sv
// AHB master mux: converts arbiter grants into address-phase and data-phase
// ownership, muxes the owners' buses, flags multi-hot grants and counts
// ownership handovers.
module ahb_master_mux #(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int unsigned DEF_MASTER = 0
) (
  input  logic              clk,
  input  logic              rst,
  ahb_master_mux_if.slave   bus
);

  localparam logic [1:0] DEF = DEF_MASTER[1:0];

  logic [3:0]    grant_vec;
  logic [1:0]    gsel;
  logic          err_now;
  logic [1:0]    hmaster_q;
  logic [1:0]    hmaster_data_q;
  logic          data_active_q;
  logic          grant_err_q;
  logic [7:0]    err_cnt_q;
  logic [15:0]   handover_cnt_q;
  logic [AW-1:0] haddr_mux;
  logic [1:0]    htrans_mux;
  logic          hwrite_mux;
  logic [2:0]    hsize_mux;
  logic [DW-1:0] hwdata_mux;

  // Grant paths may come from gated logic; anything not a clean 1 counts as 0.
  assign grant_vec[0] = (bus.grant_0 === 1'b1);
  assign grant_vec[1] = (bus.grant_1 === 1'b1);
  assign grant_vec[2] = (bus.grant_2 === 1'b1);
  assign grant_vec[3] = (bus.grant_3 === 1'b1);

  // Grant decode: lowest asserted index wins, no grant keeps the current owner.
  always_comb begin
    gsel    = hmaster_q;
    err_now = 1'b0;
    if (grant_vec != 4'b0000) begin
      err_now = ((grant_vec & (grant_vec - 4'd1)) != 4'b0000);
      if (grant_vec[0])      gsel = 2'd0;
      else if (grant_vec[1]) gsel = 2'd1;
      else if (grant_vec[2]) gsel = 2'd2;
      else                   gsel = 2'd3;
    end
  end

  // Address-phase mux, selected by the registered address-phase owner.
  always_comb begin
    haddr_mux  = bus.haddr_0;
    htrans_mux = bus.htrans_0;
    hwrite_mux = bus.hwrite_0;
    hsize_mux  = bus.hsize_0;
    case (hmaster_q)
      2'd1: begin
        haddr_mux  = bus.haddr_1;
        htrans_mux = bus.htrans_1;
        hwrite_mux = bus.hwrite_1;
        hsize_mux  = bus.hsize_1;
      end
      2'd2: begin
        haddr_mux  = bus.haddr_2;
        htrans_mux = bus.htrans_2;
        hwrite_mux = bus.hwrite_2;
        hsize_mux  = bus.hsize_2;
      end
      2'd3: begin
        haddr_mux  = bus.haddr_3;
        htrans_mux = bus.htrans_3;
        hwrite_mux = bus.hwrite_3;
        hsize_mux  = bus.hsize_3;
      end
      default: ;
    endcase
  end

  // Write-data mux follows the data-phase owner even when no transfer is active.
  always_comb begin
    case (hmaster_data_q)
      2'd1:    hwdata_mux = bus.hwdata_1;
      2'd2:    hwdata_mux = bus.hwdata_2;
      2'd3:    hwdata_mux = bus.hwdata_3;
      default: hwdata_mux = bus.hwdata_0;
    endcase
  end

  // Ownership pipeline and counters advance only on handover (hready) edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      hmaster_q      <= DEF;
      hmaster_data_q <= DEF;
      data_active_q  <= 1'b0;
      grant_err_q    <= 1'b0;
      err_cnt_q      <= 8'd0;
      handover_cnt_q <= 16'd0;
    end else if (bus.hready) begin
      hmaster_data_q <= hmaster_q;
      data_active_q  <= htrans_mux[1];
      hmaster_q      <= gsel;
      grant_err_q    <= err_now;
      if (err_now && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
      if (gsel != hmaster_q)
        handover_cnt_q <= handover_cnt_q + 16'd1;
    end else begin
      grant_err_q <= 1'b0;
    end
  end

  assign bus.haddr        = haddr_mux;
  assign bus.htrans       = htrans_mux;
  assign bus.hwrite       = hwrite_mux;
  assign bus.hsize        = hsize_mux;
  assign bus.hwdata       = hwdata_mux;
  assign bus.hmaster      = hmaster_q;
  assign bus.hmaster_data = hmaster_data_q;
  assign bus.data_active  = data_active_q;
  assign bus.grant_err    = grant_err_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.handover_cnt = handover_cnt_q;

endmodule

// File: tb/tb_ahb_master_mux.sv
// Scoreboard bench for ahb_master_mux: directed scenarios then random traffic,
// checked against a transaction-level ownership model.
module tb_ahb_master_mux;

  localparam int DEF = 0;

  logic clk = 1'b0;
  logic rst;
  logic hrdy;
  logic        g  [4];
  logic [31:0] ad [4];
  logic [1:0]  tr [4];
  logic        wr [4];
  logic [2:0]  sz [4];
  logic [31:0] wd [4];

  int n_cmp = 0;
  int n_err = 0;

  ahb_master_mux_if #(.AW(32), .DW(32)) bus ();

  ahb_master_mux #(.AW(32), .DW(32), .DEF_MASTER(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.hready   = hrdy;
  assign bus.grant_0  = g[0];
  assign bus.grant_1  = g[1];
  assign bus.grant_2  = g[2];
  assign bus.grant_3  = g[3];
  assign bus.haddr_0  = ad[0];
  assign bus.haddr_1  = ad[1];
  assign bus.haddr_2  = ad[2];
  assign bus.haddr_3  = ad[3];
  assign bus.htrans_0 = tr[0];
  assign bus.htrans_1 = tr[1];
  assign bus.htrans_2 = tr[2];
  assign bus.htrans_3 = tr[3];
  assign bus.hwrite_0 = wr[0];
  assign bus.hwrite_1 = wr[1];
  assign bus.hwrite_2 = wr[2];
  assign bus.hwrite_3 = wr[3];
  assign bus.hsize_0  = sz[0];
  assign bus.hsize_1  = sz[1];
  assign bus.hsize_2  = sz[2];
  assign bus.hsize_3  = sz[3];
  assign bus.hwdata_0 = wd[0];
  assign bus.hwdata_1 = wd[1];
  assign bus.hwdata_2 = wd[2];
  assign bus.hwdata_3 = wd[3];

  always #5 clk = ~clk;

  // Reference model: who owns the address phase, who owns the data phase.
  int  m_own, m_down, m_ec, m_hc;
  bit  m_da, m_ge, mv;

  typedef struct {
    logic [1:0]  hm;
    logic [1:0]  hmd;
    logic        da;
    logic        ge;
    logic [7:0]  ec;
    logic [15:0] hc;
    logic [31:0] addr;
    logic [1:0]  trn;
    logic        wrt;
    logic [2:0]  siz;
    logic [31:0] wdat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int hits[$];
    int nxt;
    if (rst) begin
      m_own = DEF; m_down = DEF; m_da = 0; m_ge = 0; m_ec = 0; m_hc = 0;
      mv = 1;
    end else if (mv && hrdy) begin
      for (int i = 0; i < 4; i++) if (g[i] === 1'b1) hits.push_back(i);
      nxt = (hits.size() == 0) ? m_own : hits[0];
      m_da   = (tr[m_own] == 2'b10) || (tr[m_own] == 2'b11);
      m_down = m_own;
      m_ge   = (hits.size() > 1);
      if (m_ge) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
      if (nxt != m_own) m_hc = (m_hc + 1) % 65536;
      m_own = nxt;
    end else if (mv) begin
      m_ge = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    if (!mv) return;
    e.hm   = 2'(m_own);
    e.hmd  = 2'(m_down);
    e.da   = m_da;
    e.ge   = m_ge;
    e.ec   = 8'(m_ec);
    e.hc   = 16'(m_hc);
    e.addr = ad[m_own];
    e.trn  = tr[m_own];
    e.wrt  = wr[m_own];
    e.siz  = sz[m_own];
    e.wdat = wd[m_down];
    sb.push_back(e);
  endtask

  // Publish expectations for the current inputs, then take one clock edge.
  task automatic tick();
    push_exp();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic set_grant(input logic [3:0] v);
    for (int i = 0; i < 4; i++) g[i] = v[i];
  endtask

  // Monitor: every falling edge the DUT presents a full bus state to compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hmaster",      64'(bus.hmaster),      64'(e.hm));
        chk("hmaster_data", 64'(bus.hmaster_data), 64'(e.hmd));
        chk("data_active",  64'(bus.data_active),  64'(e.da));
        chk("grant_err",    64'(bus.grant_err),    64'(e.ge));
        chk("err_cnt",      64'(bus.err_cnt),      64'(e.ec));
        chk("handover_cnt", 64'(bus.handover_cnt), 64'(e.hc));
        chk("haddr",        64'(bus.haddr),        64'(e.addr));
        chk("htrans",       64'(bus.htrans),       64'(e.trn));
        chk("hwrite",       64'(bus.hwrite),       64'(e.wrt));
        chk("hsize",        64'(bus.hsize),        64'(e.siz));
        chk("hwdata",       64'(bus.hwdata),       64'(e.wdat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_own, saved_hc, r;
    mv = 0;
    rst = 1'b1;
    hrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g[i] = 1'b0; ad[i] = $urandom; tr[i] = 2'b00; wr[i] = 1'b0; sz[i] = 3'd2; wd[i] = $urandom;
    end

    // Scenario 1: grant_2 held through reset release.
    set_grant(4'b0100);
    tick();
    rst = 1'b0;
    tick();
    #1 chk("s1_hmaster", 64'(bus.hmaster), 64'd2);
    #1;
    tick();
    #1 chk("s1_hmaster_data", 64'(bus.hmaster_data), 64'd2);
    chk("s1_handover", 64'(bus.handover_cnt), 64'd1);
    #1;

    // Scenario 2: grant moves 1 -> 3 during wait states.
    set_grant(4'b0010);
    tick(); tick();
    set_grant(4'b1000);
    hrdy = 1'b0;
    tick(); tick(); tick();
    #1 chk("s2_hold", 64'(bus.hmaster), 64'd1);
    #1;
    hrdy = 1'b1;
    tick();
    #1 chk("s2_switch", 64'(bus.hmaster), 64'd3);
    #1;

    // Scenario 3: master 1 NONSEQ then handover to master 3.
    set_grant(4'b0010);
    tick(); tick();
    tr[1] = 2'b10; ad[1] = 32'h1000_0040; wr[1] = 1'b1;
    set_grant(4'b1000);
    tick();
    #1 chk("s3_data_active", 64'(bus.data_active), 64'd1);
    chk("s3_hmaster_data", 64'(bus.hmaster_data), 64'd1);
    chk("s3_hwdata", 64'(bus.hwdata), 64'(wd[1]));
    chk("s3_haddr", 64'(bus.haddr), 64'(ad[3]));
    #1;
    tr[1] = 2'b00;

    // Scenario 4: multi-hot grants, then saturation of err_cnt.
    set_grant(4'b0101);
    tick();
    #1 chk("s4_owner", 64'(bus.hmaster), 64'd0);
    chk("s4_pulse", 64'(bus.grant_err), 64'd1);
    chk("s4_err_cnt", 64'(bus.err_cnt), 64'd1);
    #1;
    set_grant(4'b0000);
    tick();
    #1 chk("s4_pulse_end", 64'(bus.grant_err), 64'd0);
    #1;
    set_grant(4'b0101);
    for (int i = 0; i < 300; i++) tick();
    #1 chk("s4_saturate", 64'(bus.err_cnt), 64'd255);
    #1;

    // Scenario 5: no grants for 10 handover edges.
    set_grant(4'b0100);
    tick();
    set_grant(4'b0000);
    saved_own = m_own;
    saved_hc  = m_hc;
    for (int i = 0; i < 10; i++) tick();
    #1 chk("s5_owner", 64'(bus.hmaster), 64'(saved_own));
    chk("s5_handover", 64'(bus.handover_cnt), 64'(saved_hc));
    #1;

    // Scenario 6: reset during an active data phase.
    tr[2] = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    #1 chk("s6_hmaster", 64'(bus.hmaster), 64'(DEF));
    chk("s6_hmaster_data", 64'(bus.hmaster_data), 64'(DEF));
    chk("s6_data_active", 64'(bus.data_active), 64'd0);
    chk("s6_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("s6_handover", 64'(bus.handover_cnt), 64'd0);
    #1;
    rst = 1'b0;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      hrdy = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r < 6)      set_grant(4'b0001 << $urandom_range(0, 3));
      else if (r < 8) set_grant(4'b0000);
      else            set_grant(4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) begin
        ad[i] = $urandom; wd[i] = $urandom;
        tr[i] = 2'($urandom_range(0, 3));
        wr[i] = 1'($urandom_range(0, 1));
        sz[i] = 3'($urandom_range(0, 7));
      end
      tick();
    end
    rst = 1'b0;
    tick();

    @(negedge clk);
    #1 chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
